// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter producing a registered
// 2-bit grant index plus grant-valid for a downstream 2-to-4 one-hot decoder.
// A grant is held until the owner signals done or drops its request, and a
// watchdog forces release after MAX_HOLD cycles (MAX_HOLD=0 disables it).
// A release always passes through IDLE, so gnt_vld drops for at least one
// cycle between grants and the decoder never switches between two codes.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_vld,
  output logic       o_timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX     = CNT_W'(MAX_HOLD);
  localparam logic             LP_WDOG_EN = (MAX_HOLD != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;
  logic [1:0]       r_gnt_idx;
  logic [1:0]       w_gnt_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic [1:0]       w_cand;
  logic [1:0]       w_pick;
  logic             w_found;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_wdog;
  logic             w_release;

  // Round-robin search: first set request after the last grant, wrapping mod 4
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Release causes for the current owner: done, request dropped, watchdog expiry
  always_comb begin
    w_rel_done = i_done;
    w_rel_drop = ~i_req[r_gnt_idx];
    w_rel_wdog = LP_WDOG_EN && (r_cnt == LP_MAX);
    w_release  = w_rel_done | w_rel_drop | w_rel_wdog;
  end

  // Next-state and next-output logic; timeout flags a release caused only by the watchdog
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gnt_idx_nxt = r_gnt_idx;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_GRANT;
          w_gnt_idx_nxt = w_pick;
          w_cnt_nxt     = CNT_W'(1);
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt   = S_IDLE;
          w_last_nxt    = r_gnt_idx;
          w_cnt_nxt     = '0;
          w_timeout_nxt = w_rel_wdog & ~w_rel_done & ~w_rel_drop;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset gives requester 0 top priority
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_last    <= 2'd3;
      r_gnt_idx <= 2'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_gnt_idx = r_gnt_idx;
  assign o_gnt_vld = (r_state == S_GRANT);
  assign o_timeout = r_timeout;

endmodule
